// File: rtl/machine_pkg.sv
// Shared definitions for the four-machine request side.
// Holds machine count, per-machine FSM state encoding and default widths.
package machine_pkg;

    localparam int NUM_MACH  = 4;
    localparam int DEF_CNT_W = 8;
    localparam int DEF_PRE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RUN  = 2'd2,
        HOLD = 2'd3
    } mach_state_t;

endpackage

// File: rtl/machine_job_fsm.sv
// One machine's job sequencer: IDLE/REQ/RUN/HOLD plus remaining-cycle count.
// Ports: clk, rst_n, start, abort, dur, c (grant) in; m, busy, done,
//        preempt_pulse (RUN->HOLD this cycle), err_pulse (grant while idle) out.
module machine_job_fsm
    import machine_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] dur,
    input  logic             c,
    output logic             m,
    output logic             busy,
    output logic             done,
    output logic             preempt_pulse,
    output logic             err_pulse
);

    mach_state_t      state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             done_q, done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        rem_d         = rem_q;
        done_d        = 1'b0;
        preempt_pulse = 1'b0;
        unique case (state_q)
            IDLE: begin
                // abort in the same cycle suppresses the start
                if (start && !abort && dur != '0) begin
                    state_d = REQ;
                    rem_d   = dur;
                end
            end
            REQ, RUN, HOLD: begin
                if (abort) begin
                    // abort beats a grant; the granted cycle is not counted
                    state_d = IDLE;
                    rem_d   = '0;
                end else if (c) begin
                    if (rem_q == CNT_W'(1)) begin
                        state_d = IDLE;
                        rem_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RUN;
                        rem_d   = rem_q - CNT_W'(1);
                    end
                end else if (state_q == RUN) begin
                    state_d       = HOLD;
                    preempt_pulse = 1'b1;
                end
            end
        endcase
    end

    assign m         = (state_q != IDLE);
    assign busy      = m;
    assign done      = done_q;
    assign err_pulse = c && (state_q == IDLE);

endmodule

// File: rtl/machine_requester.sv
// Request side of the four-machine power-allocation interface.
// In: clk, rst_n, start[3:0], abort[3:0], dur, c[3:0] (grants).
// Out: m[3:0] requests, busy[3:0], done[3:0], sticky err, saturating preempts.
module machine_requester
    import machine_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int PRE_W = DEF_PRE_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_MACH-1:0] start,
    input  logic [NUM_MACH-1:0] abort,
    input  logic [CNT_W-1:0]    dur,
    input  logic [NUM_MACH-1:0] c,
    output logic [NUM_MACH-1:0] m,
    output logic [NUM_MACH-1:0] busy,
    output logic [NUM_MACH-1:0] done,
    output logic                err,
    output logic [PRE_W-1:0]    preempts
);

    logic [NUM_MACH-1:0] pre_pulse;
    logic [NUM_MACH-1:0] err_pulse;

    for (genvar i = 0; i < NUM_MACH; i++) begin : g_mach
        machine_job_fsm #(
            .CNT_W(CNT_W)
        ) u_fsm (
            .clk          (clk),
            .rst_n        (rst_n),
            .start        (start[i]),
            .abort        (abort[i]),
            .dur          (dur),
            .c            (c[i]),
            .m            (m[i]),
            .busy         (busy[i]),
            .done         (done[i]),
            .preempt_pulse(pre_pulse[i]),
            .err_pulse    (err_pulse[i])
        );
    end

    logic             err_q, err_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [2:0]       n_pre;
    logic [PRE_W:0]   pre_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
            pre_q <= '0;
        end else begin
            err_q <= err_d;
            pre_q <= pre_d;
        end
    end

    always_comb begin
        n_pre = '0;
        for (int i = 0; i < NUM_MACH; i++) begin
            n_pre = n_pre + 3'(pre_pulse[i]);
        end
        // one spare bit catches the carry for saturation
        pre_sum = {1'b0, pre_q} + (PRE_W+1)'(n_pre);
        pre_d   = pre_sum[PRE_W] ? '1 : pre_sum[PRE_W-1:0];
        err_d   = err_q | (|err_pulse);
    end

    assign err      = err_q;
    assign preempts = pre_q;

endmodule

// File: tb/tb_machine_requester.sv
// Self-checking bench for machine_requester: table rows feed a scoreboard,
// then preempt saturation and asynchronous reset sequences.
module tb_machine_requester;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] start, abort, c, m, busy, done;
    logic [7:0] dur, preempts;
    logic       err;

    logic       fen;
    logic [3:0] fc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    machine_requester dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .abort   (abort),
        .dur     (dur),
        .c       (c),
        .m       (m),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .preempts(preempts)
    );

    // plant grant rule, overridable for protocol-error and saturation tests
    logic [1:0] n012;
    always_comb begin
        n012 = 2'(m[0]) + 2'(m[1]) + 2'(m[2]);
        c    = {m[3] & (n012 <= 2'd1), m[2] & ~(m[0] & m[1]), m[1], m[0]};
        if (fen) c = fc;
    end

    typedef struct {
        logic [3:0] st;
        logic [3:0] ab;
        logic [7:0] du;
        logic       fe;
        logic [3:0] fcv;
        logic [3:0] em;
        logic [3:0] ed;
        logic       ee;
        logic [7:0] ep;
    } vec_t;

    vec_t tbl [35];
    vec_t sb  [$];

    function automatic vec_t v(logic [3:0] st, logic [3:0] ab, logic [7:0] du,
                               logic fe, logic [3:0] fcv, logic [3:0] em,
                               logic [3:0] ed, logic ee, logic [7:0] ep);
        vec_t r;
        r.st = st; r.ab = ab; r.du = du; r.fe = fe; r.fcv = fcv;
        r.em = em; r.ed = ed; r.ee = ee; r.ep = ep;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in;
        start = '0; abort = '0; dur = '0; fen = 1'b0; fc = '0;
    endtask

    initial begin
        vec_t e;
        // single job
        tbl[0]  = v(4'h1, 4'h0, 8'd5, 0, 0, 4'h1, 4'h0, 0, 8'd0);
        tbl[1]  = v(4'h0, 4'h0, 8'd0, 0, 0, 4'h1, 4'h0, 0, 8'd0);
        tbl[2]  = v(4'h0, 4'h0, 8'd0, 0, 0, 4'h1, 4'h0, 0, 8'd0);
        tbl[3]  = v(4'h0, 4'h0, 8'd0, 0, 0, 4'h1, 4'h0, 0, 8'd0);
        tbl[4]  = v(4'h0, 4'h0, 8'd0, 0, 0, 4'h1, 4'h0, 0, 8'd0);
        tbl[5]  = v(4'h0, 4'h0, 8'd0, 0, 0, 4'h0, 4'h1, 0, 8'd0);
        tbl[6]  = v(4'h0, 4'h0, 8'd0, 0, 0, 4'h0, 4'h0, 0, 8'd0);
        // preemption of machine 2 by 0 and 1
        tbl[7]  = v(4'h4, 4'h0, 8'd4, 0, 0, 4'h4, 4'h0, 0, 8'd0);
        tbl[8]  = v(4'h0, 4'h0, 8'd0, 0, 0, 4'h4, 4'h0, 0, 8'd0);
        tbl[9]  = v(4'h3, 4'h0, 8'd3, 0, 0, 4'h7, 4'h0, 0, 8'd0);
        tbl[10] = v(4'h0, 4'h0, 8'd0, 0, 0, 4'h7, 4'h0, 0, 8'd1);
        tbl[11] = v(4'h0, 4'h0, 8'd0, 0, 0, 4'h7, 4'h0, 0, 8'd1);
        tbl[12] = v(4'h0, 4'h0, 8'd0, 0, 0, 4'h4, 4'h3, 0, 8'd1);
        tbl[13] = v(4'h0, 4'h0, 8'd0, 0, 0, 4'h4, 4'h0, 0, 8'd1);
        tbl[14] = v(4'h0, 4'h0, 8'd0, 0, 0, 4'h0, 4'h4, 0, 8'd1);
        tbl[15] = v(4'h0, 4'h0, 8'd0, 0, 0, 4'h0, 4'h0, 0, 8'd1);
        // machine 3 starves in REQ (no preempt counted)
        tbl[16] = v(4'hB, 4'h0, 8'd2, 0, 0, 4'hB, 4'h0, 0, 8'd1);
        tbl[17] = v(4'h0, 4'h0, 8'd0, 0, 0, 4'hB, 4'h0, 0, 8'd1);
        tbl[18] = v(4'h0, 4'h0, 8'd0, 0, 0, 4'h8, 4'h3, 0, 8'd1);
        tbl[19] = v(4'h0, 4'h0, 8'd0, 0, 0, 4'h8, 4'h0, 0, 8'd1);
        tbl[20] = v(4'h0, 4'h0, 8'd0, 0, 0, 4'h0, 4'h8, 0, 8'd1);
        // abort in RUN with rem=3, then start+abort in IDLE
        tbl[21] = v(4'h2, 4'h0, 8'd5, 0, 0, 4'h2, 4'h0, 0, 8'd1);
        tbl[22] = v(4'h0, 4'h0, 8'd0, 0, 0, 4'h2, 4'h0, 0, 8'd1);
        tbl[23] = v(4'h0, 4'h0, 8'd0, 0, 0, 4'h2, 4'h0, 0, 8'd1);
        tbl[24] = v(4'h0, 4'h2, 8'd0, 0, 0, 4'h0, 4'h0, 0, 8'd1);
        tbl[25] = v(4'h2, 4'h2, 8'd5, 0, 0, 4'h0, 4'h0, 0, 8'd1);
        tbl[26] = v(4'h0, 4'h0, 8'd0, 0, 0, 4'h0, 4'h0, 0, 8'd1);
        // dur=0, back-to-back restart, protocol error
        tbl[27] = v(4'hF, 4'h0, 8'd0, 0, 0, 4'h0, 4'h0, 0, 8'd1);
        tbl[28] = v(4'h1, 4'h0, 8'd2, 0, 0, 4'h1, 4'h0, 0, 8'd1);
        tbl[29] = v(4'h0, 4'h0, 8'd0, 0, 0, 4'h1, 4'h0, 0, 8'd1);
        tbl[30] = v(4'h0, 4'h0, 8'd0, 0, 0, 4'h0, 4'h1, 0, 8'd1);
        tbl[31] = v(4'h1, 4'h0, 8'd1, 0, 0, 4'h1, 4'h0, 0, 8'd1);
        tbl[32] = v(4'h0, 4'h0, 8'd0, 0, 0, 4'h0, 4'h1, 0, 8'd1);
        tbl[33] = v(4'h0, 4'h0, 8'd0, 1, 4'h4, 4'h0, 4'h0, 1, 8'd1);
        tbl[34] = v(4'h0, 4'h0, 8'd0, 0, 0, 4'h0, 4'h0, 1, 8'd1);

        rst_n = 1'b0;
        idle_in();
        #1;
        chk("reset_m", 32'(m), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_err", 32'(err), 0);
        chk("reset_pre", 32'(preempts), 0);
        #20;
        rst_n = 1'b1;

        for (int i = 0; i < 35; i++) begin
            start = tbl[i].st;
            abort = tbl[i].ab;
            dur   = tbl[i].du;
            fen   = tbl[i].fe;
            fc    = tbl[i].fcv;
            sb.push_back(tbl[i]);
            step();
            e = sb.pop_front();
            chk($sformatf("row%0d_m", i), 32'(m), 32'(e.em));
            chk($sformatf("row%0d_busy", i), 32'(busy), 32'(e.em));
            chk($sformatf("row%0d_done", i), 32'(done), 32'(e.ed));
            chk($sformatf("row%0d_err", i), 32'(err), 32'(e.ee));
            chk($sformatf("row%0d_pre", i), 32'(preempts), 32'(e.ep));
        end
        chk("sb_empty", 32'(sb.size()), 0);

        // all four preempted together: +4 per cycle, saturating at 255
        idle_in();
        start = 4'hF;
        dur   = 8'd200;
        step();
        start = '0;
        fen   = 1'b1;
        for (int k = 0; k < 70; k++) begin
            fc = 4'hF;
            step();
            fc = 4'h0;
            step();
            if (k == 9) begin
                chk("pre_multi", 32'(preempts), 41);
                chk("pre_busy", 32'(busy), 32'hF);
            end
        end
        chk("pre_sat", 32'(preempts), 255);
        abort = 4'hF;
        step();
        idle_in();
        chk("sat_abort_m", 32'(m), 0);
        chk("sat_abort_done", 32'(done), 0);
        chk("sat_hold", 32'(preempts), 255);

        // asynchronous reset mid-job
        start = 4'hF;
        dur   = 8'd9;
        step();
        idle_in();
        step();
        chk("pre_rst_m", 32'(m), 32'hF);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_m", 32'(m), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_pre", 32'(preempts), 0);
        chk("arst_err", 32'(err), 0);
        chk("arst_done", 32'(done), 0);
        #2;
        rst_n = 1'b1;
        start = 4'h8;
        dur   = 8'd1;
        step();
        idle_in();
        chk("post_rst_m", 32'(m), 32'h8);
        step();
        chk("post_rst_done", 32'(done), 32'h8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/machine_requester.md
# machine_requester

Sequential request side of the four-machine power-allocation interface. Accepts job commands (start plus duration) for machines 0..3 and drives the request lines `m[3:0]` into the grant logic. It counts only the cycles in which each machine's grant `c[i]` is high, and tolerates preemption by higher-priority machines. It reports per-machine busy and done, a sticky protocol error, and a total preemption count.

## Interface
- `CNT_W`, 8: width of the job duration and of the remaining-cycle counters.
- `PRE_W`, 8: width of the saturating preemption counter.

- `clk`  in  1  single system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  4  one-cycle job start per machine.
- `abort`  in  4  one-cycle job cancel per machine.
- `dur`  in  CNT_W  job length in granted cycles; sampled for every machine whose `start` is accepted that cycle.
- `c`  in  4  grant per machine from the allocation logic, combinational from `m`.
- `m`  out  4  registered request per machine.
- `busy`  out  4  machine has an accepted, unfinished job.
- `done`  out  4  one-cycle pulse when the job completes normally.
- `err`  out  1  sticky: a grant was seen while the machine's request was low.
- `preempts`  out  PRE_W  saturating count of RUN-to-HOLD transitions, summed over all machines.

## Operation
- Each machine runs an independent FSM with states IDLE, REQ, RUN and HOLD, plus a `rem` counter of CNT_W bits.
- **IDLE** (`m=0`, `busy=0`):
  - `start[i]` with `dur!=0` and no `abort[i]`: load `rem=dur` and go to REQ.
  - `start[i]` with `dur==0`: ignored, no state change, no `done`.
- **REQ** (`m=1`): requested, never granted yet.
  - `c[i]=1`: decrement `rem`; go to RUN, or complete if `rem` was 1.
  - `c[i]=0`: stay in REQ.
- **RUN** (`m=1`): granted in the previous cycle.
  - `c[i]=1`: decrement `rem`; complete when `rem` was 1.
  - `c[i]=0`: go to HOLD and increment `preempts`.
- **HOLD** (`m=1`): preempted. Keeps requesting and keeps `rem`; `c[i]=1` resumes exactly as in REQ.
- **Completion:** go to IDLE, `m[i]` falls, `done[i]=1` for exactly one cycle.
- **Abort:** `abort[i]` in REQ, RUN or HOLD forces IDLE next cycle with no `done`.
  - Abort wins over a grant in the same cycle; that cycle is not counted.
  - `abort[i]` in IDLE is ignored, and it also blocks a simultaneous `start[i]`.
- `start[i]` outside IDLE is ignored; the running job is unaffected.
- **Protocol error:** `c[i]=1` while `m[i]=0` sets `err` (sticky until reset); the grant is otherwise ignored.
- `preempts` saturates at all-ones. If several machines are preempted in the same cycle, it adds the number of preempted machines.
- **Reset outputs:** `m=0`, `busy=0`, `done=0`, `err=0`, `preempts=0`. All FSMs go to IDLE and `rem=0`.

## Timing
- Start accepted at edge t → `m[i]` and `busy[i]` high from t+1.
- Grant is sampled at each rising edge while `m[i]=1`.
- Uninterrupted job of length N: `m[i]` high for exactly N cycles. `done[i]` pulses in cycle N+1 relative to the first `m` cycle, the same cycle `m[i]` falls; `busy[i]` falls with it.
- With preemption: `m[i]` high for N plus the number of ungranted cycles.
- Back-to-back jobs: `start[i]` in the `done[i]` cycle is accepted, so `m[i]` is low for exactly one cycle.
- Abort at edge t → `m[i]=0` and `busy[i]=0` from t+1.
- Asynchronous reset mid-job: `m` drops immediately on `rst_n` fall, no `done`. The first start is accepted on the first edge after `rst_n` rises.

## Structure
- Package `machine_pkg`:
  - `NUM_MACH=4`.
  - State enum `mach_state_t` {IDLE, REQ, RUN, HOLD}.
  - Default `CNT_W`.
- Sub-module `machine_job_fsm`: one FSM plus `rem`. Ports `clk`, `rst_n`, `start`, `abort`, `dur`, `c`, `m`, `busy`, `done`, `preempt_pulse`, `err_pulse`.
- Top instantiates four `machine_job_fsm` instances. The top holds the `err` flag and the `preempts` adder/saturator.

## Test plan
The bench drives `c` with the plant grant rule:
- `c0=m0`
- `c1=m1`
- `c2=m2 & ~(m0&m1)`
- `c3=m3` & (at most one of `m0`..`m2`)

Directed scenarios:
1. **Single job:** `start=0001`, `dur=5` → `m0` high for 5 cycles, `done0` pulse on the 6th, `preempts=0`.
2. **Preemption:** start machine 2 with `dur=4`; 2 cycles later start machines 0 and 1 with `dur=3` → `m2` loses grant for 3 cycles, `preempts=1`, `done2` arrives 7 cycles after `m2` rose.
3. **Machine 3 starvation:** jobs on 0, 1 and 3 with `dur=2` → `m3` waits in REQ with `rem` unchanged until 0 and 1 finish, then 2 granted cycles.
4. **Abort:** abort machine 1 in RUN with `rem=3` → `m1=0` next cycle, no `done1`. Simultaneous `start1`+`abort1` in IDLE → stays IDLE.
5. **Edge cases:**
   - `dur=0` start → ignored.
   - `start` during `done` → restart with a one-cycle `m` gap.
   - Forced `c=0100` with `m=0000` → `err=1` and stays 1.
6. **Async reset:** `rst_n` low mid-job on all four machines → `m=0000` immediately. `preempts`, `err` and `busy` reach 0 without a clock edge.
